// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel, W-bit stream multiplexer with valid/ready inputs,
// a fixed-select or round-robin grant, and a one-entry registered output stage.
//
// Handshake rule used on every port: a word moves on a rising clock edge when
// valid and ready are both high in that cycle. A producer keeps valid and data
// steady until the word moves. in_ready is combinational and at most one bit
// is high at a time. out_data/out_chan do not change while out_valid=1 and
// out_ready=0.
module stream_mux_arb #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_W-1:0]             out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
);

    // After reset the pointer sits on the highest channel so channel 0 wins first.
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             can_load;
    logic             load;

    // Pick the granted channel: the sel channel in fixed mode (an out-of-range
    // sel matches no channel), otherwise the first valid channel after last.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = (int'(last) + k) % CHANNELS;
                if (!grant_vld && in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    // Accept only when the output register is free or draining this cycle;
    // nothing is accepted while reset is held.
    always_comb begin
        can_load = !out_valid || out_ready;
        load     = can_load && grant_vld && reset_n;
        in_ready = '0;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register: reload on an input transfer, empty on a pure drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer follows every accepted word, whichever mode granted it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= LAST_RST;
        end else if (load) begin
            last <= grant_idx;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: directed scenarios plus random traffic, all
// compared against a transaction-level reference model of the mux.
module tb_stream_mux_arb;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-channel DUT ----------------
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    stream_mux_arb #(.WIDTH(16), .CHANNELS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // ---------------- 6-channel DUT (out-of-range sel) ----------------
    logic [95:0] d6_in_data;
    logic [5:0]  d6_in_valid;
    logic [5:0]  d6_in_ready;
    logic        d6_mode;
    logic [2:0]  d6_sel;
    logic [15:0] d6_out_data;
    logic [2:0]  d6_out_chan;
    logic        d6_out_valid;
    logic        d6_out_ready;

    stream_mux_arb #(.WIDTH(16), .CHANNELS(6)) dut6 (
        .clk(clk), .reset_n(reset_n),
        .in_data(d6_in_data), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
        .mode(d6_mode), .sel(d6_sel),
        .out_data(d6_out_data), .out_chan(d6_out_chan), .out_valid(d6_out_valid),
        .out_ready(d6_out_ready)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    // Reference model of the 4-channel DUT, kept at transaction level.
    int          m_last;
    logic        m_ov;
    logic [15:0] m_od;
    int          m_oc;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner for a request vector: fixed mode takes sel if it is a real,
    // requesting channel; round-robin walks the priority list after last.
    function automatic int model_grant(input logic [7:0] v, input logic m, input int s,
                                       input int lst, input int nch);
        int order[$];
        if (!m) begin
            return (s < nch && v[s]) ? s : -1;
        end
        for (int k = 1; k <= nch; k++) order.push_back((lst + k) % nch);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 3;
        m_ov   = 1'b0;
        m_od   = 16'h0;
        m_oc   = 0;
        exp_q.delete();
    endtask

    // One clock cycle on the 4-channel DUT. Called just after a falling edge
    // with inputs already applied; checks outputs, then advances the model.
    task automatic tick();
        int         g;
        logic       cl;
        logic [3:0] er;
        #1;
        cl = !m_ov || out_ready;
        g  = model_grant({4'b0, in_valid}, mode, int'(sel), m_last, 4);
        er = (cl && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_chan", 32'(out_chan), 32'(m_oc));
        @(posedge clk);
        if (m_ov && out_ready) void'(exp_q.pop_front());
        if (cl && g >= 0) begin
            m_od   = in_data[g*16 +: 16];
            m_oc   = g;
            m_ov   = 1'b1;
            m_last = g;
            exp_q.push_back(m_od);
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset_n      = 1'b0;
        in_data      = '0;
        in_valid     = '0;
        mode         = 1'b0;
        sel          = '0;
        out_ready    = 1'b1;
        d6_in_data   = '0;
        d6_in_valid  = '0;
        d6_mode      = 1'b0;
        d6_sel       = '0;
        d6_out_ready = 1'b1;
        model_reset();

        // Reset state, with requests present: nothing may be accepted.
        @(negedge clk);
        in_valid = 4'b1111;
        mode     = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_chan", 32'(out_chan), 32'h0);
        @(negedge clk);
        in_valid = 4'b0000;
        mode     = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        // Six-channel block: sel=5 idle, sel=6/7 out of range, then sel=5 live.
        d6_sel      = 3'd5;
        d6_in_valid = 6'b011111;
        #1;
        chk("d6_sel5_idle", 32'(d6_in_ready), 32'h0);
        d6_sel      = 3'd6;
        d6_in_valid = 6'b111111;
        #1;
        chk("d6_sel6_oor", 32'(d6_in_ready), 32'h0);
        d6_sel = 3'd7;
        #1;
        chk("d6_sel7_oor", 32'(d6_in_ready), 32'h0);
        d6_sel                   = 3'd5;
        d6_in_valid              = 6'b100000;
        d6_in_data[5*16 +: 16]   = 16'hA5A5;
        #1;
        chk("d6_sel5_ready", 32'(d6_in_ready), 32'h20);
        @(posedge clk);
        @(negedge clk);
        d6_in_valid = '0;
        chk("d6_out_valid", 32'(d6_out_valid), 32'h1);
        chk("d6_out_data", 32'(d6_out_data), 32'hA5A5);
        chk("d6_out_chan", 32'(d6_out_chan), 32'h5);
        @(posedge clk);
        @(negedge clk);
        chk("d6_drained", 32'(d6_out_valid), 32'h0);

        // Fixed mode, sel=2, single request.
        mode                = 1'b0;
        sel                 = 2'd2;
        in_valid            = 4'b0100;
        in_data[2*16 +: 16] = 16'hBEEF;
        out_ready           = 1'b1;
        #1;
        chk("fix_ready", 32'(in_ready), 32'h4);
        tick();
        in_valid = 4'b0000;
        chk("fix_valid", 32'(out_valid), 32'h1);
        chk("fix_data", 32'(out_data), 32'hBEEF);
        chk("fix_chan", 32'(out_chan), 32'h2);
        tick();

        // Round-robin from reset with every channel requesting.
        do_reset();
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = 16'h1000 + 16'(c);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_chan", 32'(out_chan), 32'(i % 4));
        end

        // Back-pressure: hold a word for three cycles, then release.
        in_valid = 4'b0000;
        tick();
        mode                = 1'b0;
        sel                 = 2'd0;
        in_valid            = 4'b0001;
        in_data[0*16 +: 16] = 16'h1111;
        out_ready           = 1'b0;
        tick();
        in_data[0*16 +: 16] = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h1111);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp_new_valid", 32'(out_valid), 32'h1);
        chk("bp_new_data", 32'(out_data), 32'h2222);

        // Fixed sel on an idle channel: no grant, held word drains.
        sel      = 2'd2;
        in_valid = 4'b1011;
        tick();
        chk("nogrant_drain", 32'(out_valid), 32'h0);

        // Round-robin wrap from last=1, then a same-cycle mode switch.
        do_reset();
        mode     = 1'b1;
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b0011;
        tick();
        chk("rr_wrap_chan", 32'(out_chan), 32'h0);
        mode = 1'b0;
        sel  = 2'd1;
        #1;
        chk("switch_ready", 32'(in_ready), 32'h2);
        tick();
        chk("switch_chan", 32'(out_chan), 32'h1);

        // Asynchronous reset while a word is held.
        do_reset();
        mode     = 1'b1;
        in_valid = 4'b1111;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_chan", 32'(out_chan), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("arst_first_chan", 32'(out_chan), 32'h0);
        chk("arst_first_valid", 32'(out_valid), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = 16'($urandom);
            tick();
        end

        // Drain: the last held word must match the scoreboard head.
        in_valid  = '0;
        out_ready = 1'b1;
        #1;
        if (exp_q.size() != 0) chk("drain_head", 32'(out_data), 32'(exp_q[0]));
        tick();
        chk("final_idle", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel, W-bit multiplexer with valid/ready handshakes on every input and a one-entry registered output stage. It is the next generation of the combinational 16-bit select muxes: the same select-by-index behaviour, plus a round-robin arbitration mode and back-pressure. It sits between multiple producers and one consumer, such as register-file/ALU result paths feeding a shared bus.

## Interface
- WIDTH, 16, data width in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), width of channel index (derived; do not override)

- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept; combinational; at most one bit high
- mode  input  1  0 = fixed select (use sel), 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- out_data  output  WIDTH  registered data
- out_chan  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Transfer on an input occurs when in_valid[i] & in_ready[i]. Transfer on the output occurs when out_valid & out_ready.
- can_load = !out_valid | out_ready. When can_load is 0, all in_ready bits are 0.
- Grant selection in fixed mode (mode=0): grant = sel if sel < CHANNELS and in_valid[sel]. Otherwise there is no grant. An out-of-range sel never grants and never errors.
- Grant selection in round-robin mode (mode=1): search channels last+1, last+2, … wrapping modulo CHANNELS, ending at last. Grant the first channel with in_valid high.
- last is a SEL_W-bit pointer. It updates to the granted index on every input transfer, in either mode.
- in_ready[g] = can_load & grant-exists, for granted index g only.
- On an input transfer: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- On an output transfer with no input transfer: out_valid <= 0. out_data and out_chan hold their values.
- Simultaneous output and input transfers in one cycle: the register reloads and out_valid stays 1. This gives full throughput of 1 word per cycle.
- out_data and out_chan are stable while out_valid=1 and out_ready=0.
- A mode or sel change takes effect in the same cycle's grant (both are combinational inputs). Changing mode does not reset last.
- Reset values (asynchronous on reset_n low, held until release):
  - out_valid=0, out_data=0, out_chan=0
  - last=CHANNELS-1, so channel 0 has first round-robin priority
  - in_ready is all 0 while in reset
- Reset asserted mid-stream drops any held word. No partial state survives.

## Timing
- Latency: 1 cycle from input transfer to out_valid/out_data visible.
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. There is no combinational path from in_data to any output.
- Sustained rate: 1 word/cycle when out_ready is held high.
- Round-robin fairness: with all CHANNELS inputs valid, each channel is granted exactly once per CHANNELS consecutive transfers.
- Producers must hold in_valid and in_data until their transfer; the block does not require this, but dropped words are not its responsibility.

## Test plan
- Reset, then fixed mode with WIDTH=16, CHANNELS=4, sel=2, in_valid=4'b0100, in_data[2]=16'hBEEF, out_ready=1 -> in_ready=4'b0100 in that cycle; next cycle out_valid=1, out_data=16'hBEEF, out_chan=2.
- Round-robin mode, in_valid=4'b1111 held, out_ready=1, from reset -> grants 0,1,2,3,0,1 on consecutive cycles; out_chan follows one cycle later.
- Back-pressure: a word is held, out_ready=0 for 3 cycles with in_valid=4'b0001 -> in_ready=0 throughout and out_data stable; out_ready=1 -> that cycle in_ready[0]=1, and out_valid stays 1 with new data next cycle.
- Fixed mode, sel=2 with in_valid=4'b1011, then sel=5 with CHANNELS=6 and channel 5 idle -> no grant, in_ready=0, out_valid falls after drain.
- Round-robin, last=1 with in_valid=4'b0011 -> grant 0 (wrap past 2,3); a mode switch to fixed with sel=1 the next cycle -> grant 1 immediately.
- Assert reset_n low mid-transfer while out_valid=1 -> out_valid=0, out_data=0, out_chan=0 asynchronously; after release, round-robin with in_valid=4'b1111 grants channel 0 first.
